// File: rtl/life_pkg.sv
// Shared types for the Game-of-Life line-bank scheduler.
// Holds the scheduler state enum, grid size constants and read-requester tags.
package life_pkg;

  localparam int Y_SIZE = 720;
  localparam int X_SIZE = 1280;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_START,
    S_CALC,
    S_WAIT_SWAP,
    S_SWAP
  } state_e;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_NONE = 2'd0;
  localparam tag_t TAG_DISP = 2'd1;
  localparam tag_t TAG_CALC = 2'd2;

endpackage

// File: rtl/life_rd_tag_pipe.sv
// Requester-tag shift register that tracks front-bank reads in flight.
// Ports: clk_i, rst_i (sync, active-high), tag_i (tag of this cycle's grant),
// disp_rvalid_o / calc_rvalid_o (tag leaving last stage), empty_o.
module life_rd_tag_pipe
  import life_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output logic disp_rvalid_o,
  output logic calc_rvalid_o,
  output logic empty_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_q[i] != TAG_NONE) begin
        empty_o = 1'b0;
      end
    end
  end

  assign disp_rvalid_o = (pipe_q[DEPTH-1] == TAG_DISP);
  assign calc_rvalid_o = (pipe_q[DEPTH-1] == TAG_CALC);

endmodule

// File: rtl/life_bank_scheduler.sv
// Sequences host init, generation compute and display readout over two
// Game-of-Life line banks (A/B) that swap front/back after each generation.
// Ports: out_stream_aclk, periph_reset (sync, active-high); host init_req/
// init_we; pause; display disp_sof/req/row -> disp_gnt/rvalid; compute
// calc_req/row -> calc_gnt/rvalid, calc_wr_valid/row, calc_gen_done ->
// calc_start/abort; registered bram_{a,b}_addr/we; front_bank, init_done,
// gen_count. Define LIFE_SWAP_ON_SOF_EN to align swaps with disp_sof.
module life_bank_scheduler #(
  parameter int Y_SIZE    = life_pkg::Y_SIZE,
  parameter int Y_WIDTH   = $clog2(Y_SIZE),
  parameter int RD_LAT    = 2,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 out_stream_aclk,
  input  logic                 periph_reset,
  input  logic                 init_req,
  input  logic                 init_we,
  input  logic                 pause,
  input  logic                 disp_sof,
  input  logic                 disp_req,
  input  logic [Y_WIDTH-1:0]   disp_row,
  output logic                 disp_gnt,
  output logic                 disp_rvalid,
  input  logic                 calc_req,
  input  logic [Y_WIDTH-1:0]   calc_row,
  output logic                 calc_gnt,
  output logic                 calc_rvalid,
  input  logic                 calc_wr_valid,
  input  logic [Y_WIDTH-1:0]   calc_wr_row,
  input  logic                 calc_gen_done,
  output logic                 calc_start,
  output logic                 calc_abort,
  output logic [Y_WIDTH-1:0]   bram_a_addr,
  output logic [Y_WIDTH-1:0]   bram_b_addr,
  output logic                 bram_a_we,
  output logic                 bram_b_we,
  output logic                 front_bank,
  output logic                 init_done,
  output logic [GEN_WIDTH-1:0] gen_count
);
  import life_pkg::*;

  state_e               state_q, state_d;
  logic [Y_WIDTH-1:0]   row_q, row_d;
  logic                 init_req_q;
  logic                 armed_q, armed_d;
  logic                 front_q, front_d;
  logic                 done_q, done_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic [Y_WIDTH-1:0]   a_addr_q, a_addr_d;
  logic [Y_WIDTH-1:0]   b_addr_q, b_addr_d;
  logic                 a_we_q, a_we_d;
  logic                 b_we_q, b_we_d;

  logic               init_go;
  logic               swap_cond;
  logic               swap_req;
  logic               rd_en;
  logic               init_wr;
  logic               wr_acc;
  logic               pipe_empty;
  tag_t               tag_d;
  logic [Y_WIDTH-1:0] fr_addr;
  logic [Y_WIDTH-1:0] bk_addr;

`ifndef LIFE_SWAP_ON_SOF_EN
  logic unused_sof;
  assign unused_sof = disp_sof;
`endif

  // Init restarts on any init_req outside INIT, or on a fresh rising edge.
  always_comb begin
    init_go = init_req && ((state_q != S_INIT) || !init_req_q);
`ifdef LIFE_SWAP_ON_SOF_EN
    swap_cond = disp_sof && !pause;
`else
    swap_cond = !pause;
`endif
    swap_req = (state_q == S_WAIT_SWAP) && (swap_cond || armed_q);
    // Once a swap is wanted, stop new reads so the tag pipe drains.
    rd_en    = (state_q != S_INIT) && !swap_req;
    disp_gnt = rd_en && disp_req;
    calc_gnt = rd_en && calc_req && !disp_req;
    init_wr  = (state_q == S_INIT) && init_we && !init_go;
    wr_acc   = (state_q == S_CALC) && calc_wr_valid && !init_go;
  end

  always_comb begin
    tag_d   = TAG_NONE;
    fr_addr = '0;
    unique case (1'b1)
      disp_gnt: begin
        tag_d   = TAG_DISP;
        fr_addr = disp_row;
      end
      calc_gnt: begin
        tag_d   = TAG_CALC;
        fr_addr = calc_row;
      end
      init_wr: fr_addr = row_q;
      default: ;
    endcase
    bk_addr = wr_acc ? calc_wr_row : '0;
    if (front_q) begin
      a_addr_d = bk_addr;
      a_we_d   = wr_acc;
      b_addr_d = fr_addr;
      b_we_d   = init_wr;
    end else begin
      a_addr_d = fr_addr;
      a_we_d   = init_wr;
      b_addr_d = bk_addr;
      b_we_d   = wr_acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    armed_d    = 1'b0;
    front_d    = front_q;
    done_d     = done_q;
    gen_d      = gen_q;
    calc_start = 1'b0;
    calc_abort = 1'b0;
    if (init_go) begin
      state_d    = S_INIT;
      row_d      = '0;
      done_d     = 1'b0;
      calc_abort = (state_q == S_CALC) || (state_q == S_WAIT_SWAP);
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_INIT: begin
          if (init_we) begin
            row_d = row_q + Y_WIDTH'(1);
            if (row_q == Y_WIDTH'(Y_SIZE - 1)) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = S_START;
            end
          end
        end
        S_START: begin
          if (!pause) begin
            calc_start = 1'b1;
            state_d    = S_CALC;
          end
        end
        S_CALC: begin
          if (calc_gen_done) begin
            state_d = S_WAIT_SWAP;
          end
        end
        S_WAIT_SWAP: begin
          // Bank flips on entry so the SWAP cycle already sees new front.
          if (swap_req) begin
            if (pipe_empty) begin
              state_d = S_SWAP;
              front_d = !front_q;
              gen_d   = gen_q + GEN_WIDTH'(1);
            end else begin
              armed_d = 1'b1;
            end
          end
        end
        S_SWAP:  state_d = S_START;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      init_req_q <= 1'b0;
      armed_q    <= 1'b0;
      front_q    <= 1'b0;
      done_q     <= 1'b0;
      gen_q      <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_we_q     <= 1'b0;
      b_we_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      init_req_q <= init_req;
      armed_q    <= armed_d;
      front_q    <= front_d;
      done_q     <= done_d;
      gen_q      <= gen_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_we_q     <= a_we_d;
      b_we_q     <= b_we_d;
    end
  end

  life_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk_i        (out_stream_aclk),
    .rst_i        (periph_reset),
    .tag_i        (tag_d),
    .disp_rvalid_o(disp_rvalid),
    .calc_rvalid_o(calc_rvalid),
    .empty_o      (pipe_empty)
  );

  assign bram_a_addr = a_addr_q;
  assign bram_b_addr = b_addr_q;
  assign bram_a_we   = a_we_q;
  assign bram_b_we   = b_we_q;
  assign front_bank  = front_q;
  assign init_done   = done_q;
  assign gen_count   = gen_q;

endmodule

// File: tb/tb_life_bank_scheduler.sv
// Self-checking bench for life_bank_scheduler: scenario tasks plus a
// randomized read/write traffic phase scored against a priority/latency model.
module tb_life_bank_scheduler;

  localparam int YS = 720;
  localparam int YW = 10;
  localparam int RL = 2;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req, init_we, pause, disp_sof;
  logic          disp_req, calc_req, calc_wr_valid, calc_gen_done;
  logic [YW-1:0] disp_row, calc_row, calc_wr_row;
  logic          disp_gnt, disp_rvalid, calc_gnt, calc_rvalid;
  logic          calc_start, calc_abort;
  logic [YW-1:0] bram_a_addr, bram_b_addr;
  logic          bram_a_we, bram_b_we;
  logic          front_bank, init_done;
  logic [GW-1:0] gen_count;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_front = 1'b0;
  int   exp_gen = 0;

  always #5 clk = ~clk;

  life_bank_scheduler #(
    .Y_SIZE(YS), .Y_WIDTH(YW), .RD_LAT(RL), .GEN_WIDTH(GW)
  ) dut (
    .out_stream_aclk(clk),
    .periph_reset   (rst),
    .init_req       (init_req),
    .init_we        (init_we),
    .pause          (pause),
    .disp_sof       (disp_sof),
    .disp_req       (disp_req),
    .disp_row       (disp_row),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .calc_req       (calc_req),
    .calc_row       (calc_row),
    .calc_gnt       (calc_gnt),
    .calc_rvalid    (calc_rvalid),
    .calc_wr_valid  (calc_wr_valid),
    .calc_wr_row    (calc_wr_row),
    .calc_gen_done  (calc_gen_done),
    .calc_start     (calc_start),
    .calc_abort     (calc_abort),
    .bram_a_addr    (bram_a_addr),
    .bram_b_addr    (bram_b_addr),
    .bram_a_we      (bram_a_we),
    .bram_b_we      (bram_b_we),
    .front_bank     (front_bank),
    .init_done      (init_done),
    .gen_count      (gen_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_req = 0; init_we = 0; pause = 0; disp_sof = 0;
    disp_req = 0; calc_req = 0; calc_wr_valid = 0; calc_gen_done = 0;
    disp_row = '0; calc_row = '0; calc_wr_row = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) tick();
    n_cmp++;
    if ({bram_a_addr, bram_b_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_addr: got a=%0d b=%0d, want 0 0", bram_a_addr, bram_b_addr);
    end
    n_cmp++;
    if ({bram_a_we, bram_b_we} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_we: got %b%b, want 00", bram_a_we, bram_b_we);
    end
    n_cmp++;
    if ({front_bank, init_done} !== 2'b00 || gen_count !== '0) begin
      n_err++;
      $display("FAIL reset_status: got front=%b done=%b gen=%0d, want 0 0 0",
               front_bank, init_done, gen_count);
    end
    n_cmp++;
    if ({disp_gnt, calc_gnt, disp_rvalid, calc_rvalid, calc_start, calc_abort} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b%b%b%b%b%b, want 000000", disp_gnt, calc_gnt,
               disp_rvalid, calc_rvalid, calc_start, calc_abort);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (calc_start !== 1'b0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: got start=%b done=%b, want 0 0", calc_start, init_done);
    end
  endtask

  task automatic test_init();
    init_req = 1;
    tick();
    init_req = 0;
    disp_req = 1; disp_row = 10'd3;
    calc_req = 1; calc_row = 10'd4;
    for (int r = 0; r < YS; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        init_we = 0;
        tick();
        n_cmp++;
        if (bram_a_we !== 1'b0) begin
          n_err++;
          $display("FAIL init_gap_we: got %b, want 0", bram_a_we);
        end
      end
      init_we = 1;
      #1;
      n_cmp++;
      if ({disp_gnt, calc_gnt, calc_start} !== 3'b000) begin
        n_err++;
        $display("FAIL init_no_grant r=%0d: got gnt=%b%b start=%b, want 000",
                 r, disp_gnt, calc_gnt, calc_start);
      end
      tick();
      init_we = 0;
      n_cmp++;
      if (bram_a_we !== 1'b1 || bram_a_addr !== YW'(r) || bram_b_we !== 1'b0) begin
        n_err++;
        $display("FAIL init_write r=%0d: got a_we=%b a_addr=%0d b_we=%b, want 1 %0d 0",
                 r, bram_a_we, bram_a_addr, bram_b_we, r);
      end
      n_cmp++;
      if (init_done !== (r == YS - 1)) begin
        n_err++;
        $display("FAIL init_done r=%0d: got %b, want %b", r, init_done, r == YS - 1);
      end
    end
    disp_req = 0;
    calc_req = 0;
    pause = 0;
    #1;
    n_cmp++;
    if (calc_start !== 1'b1) begin
      n_err++;
      $display("FAIL init_calc_start: got %b, want 1", calc_start);
    end
    tick();
  endtask

  task automatic test_arbitration();
    logic [YW-1:0] r1, r2;
    r1 = YW'($urandom_range(0, YS - 1));
    r2 = YW'($urandom_range(0, YS - 1));
    disp_req = 1; disp_row = r1;
    calc_req = 1; calc_row = r2;
    #1;
    n_cmp++;
    if (disp_gnt !== 1'b1 || calc_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL arb_both: got d=%b c=%b, want 1 0", disp_gnt, calc_gnt);
    end
    tick();
    disp_req = 0;
    #1;
    n_cmp++;
    if (calc_gnt !== 1'b1 || disp_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL arb_calc_next: got d=%b c=%b, want 0 1", disp_gnt, calc_gnt);
    end
    n_cmp++;
    if (bram_a_addr !== r1 || bram_a_we !== 1'b0) begin
      n_err++;
      $display("FAIL arb_addr_disp: got %0d we=%b, want %0d 0", bram_a_addr, bram_a_we, r1);
    end
    tick();
    calc_req = 0;
    n_cmp++;
    if (bram_a_addr !== r2) begin
      n_err++;
      $display("FAIL arb_addr_calc: got %0d, want %0d", bram_a_addr, r2);
    end
    n_cmp++;
    if ({disp_rvalid, calc_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL arb_early_rvalid: got %b%b, want 00", disp_rvalid, calc_rvalid);
    end
    tick();
    n_cmp++;
    if ({disp_rvalid, calc_rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL arb_disp_rvalid: got %b%b, want 10", disp_rvalid, calc_rvalid);
    end
    tick();
    n_cmp++;
    if ({disp_rvalid, calc_rvalid} !== 2'b01) begin
      n_err++;
      $display("FAIL arb_calc_rvalid: got %b%b, want 01", disp_rvalid, calc_rvalid);
    end
    tick();
  endtask

  task automatic test_calc_write();
    calc_wr_valid = 1;
    calc_wr_row = 10'd5;
    tick();
    calc_wr_valid = 0;
    n_cmp++;
    if (bram_b_we !== 1'b1 || bram_b_addr !== 10'd5 || bram_a_we !== 1'b0) begin
      n_err++;
      $display("FAIL calc_write: got b_we=%b b_addr=%0d a_we=%b, want 1 5 0",
               bram_b_we, bram_b_addr, bram_a_we);
    end
    tick();
    n_cmp++;
    if (bram_b_we !== 1'b0 || bram_b_addr !== '0) begin
      n_err++;
      $display("FAIL back_idle: got we=%b addr=%0d, want 0 0", bram_b_we, bram_b_addr);
    end
  endtask

  // Model: display beats compute, data returns RL+1 cycles after grant.
  task automatic test_random_traffic();
    localparam int N = 300;
    int            exp_rv [0:N+8];
    logic          eg_d, eg_c, wv;
    logic [YW-1:0] ea, wr;
    for (int i = 0; i <= N + 8; i++) exp_rv[i] = 0;
    for (int c = 0; c < N + 5; c++) begin
      if (c < N) begin
        if (!disp_req && $urandom_range(0, 2) == 0) begin
          disp_req = 1;
          disp_row = YW'($urandom_range(0, YS - 1));
        end
        if (!calc_req && $urandom_range(0, 1) == 0) begin
          calc_req = 1;
          calc_row = YW'($urandom_range(0, YS - 1));
        end
        calc_wr_valid = ($urandom_range(0, 1) == 1);
        calc_wr_row = YW'($urandom_range(0, YS - 1));
      end
      #1;
      eg_d = disp_req;
      eg_c = calc_req && !disp_req;
      ea = eg_d ? disp_row : calc_row;
      if (eg_d) exp_rv[c + RL + 1] = 1;
      else if (eg_c) exp_rv[c + RL + 1] = 2;
      wv = calc_wr_valid;
      wr = calc_wr_row;
      n_cmp++;
      if (disp_gnt !== eg_d || calc_gnt !== eg_c) begin
        n_err++;
        $display("FAIL rnd_gnt c=%0d: got %b%b, want %b%b", c, disp_gnt, calc_gnt, eg_d, eg_c);
      end
      tick();
      if (eg_d || eg_c) begin
        n_cmp++;
        if (bram_a_addr !== ea) begin
          n_err++;
          $display("FAIL rnd_rd_addr c=%0d: got %0d, want %0d", c, bram_a_addr, ea);
        end
      end
      n_cmp++;
      if (bram_a_we !== 1'b0 || bram_b_we !== wv || bram_b_addr !== (wv ? wr : '0)) begin
        n_err++;
        $display("FAIL rnd_wr c=%0d: got a_we=%b b_we=%b b_addr=%0d, want 0 %b %0d",
                 c, bram_a_we, bram_b_we, bram_b_addr, wv, wv ? wr : '0);
      end
      n_cmp++;
      if (disp_rvalid !== (exp_rv[c+1] == 1) || calc_rvalid !== (exp_rv[c+1] == 2)) begin
        n_err++;
        $display("FAIL rnd_rvalid c=%0d: got %b%b, want tag %0d",
                 c, disp_rvalid, calc_rvalid, exp_rv[c+1]);
      end
      if (eg_d) disp_req = 0;
      if (eg_c) calc_req = 0;
      calc_wr_valid = 0;
    end
  endtask

  task automatic test_swap();
    calc_gen_done = 1;
    tick();
    calc_gen_done = 0;
    n_cmp++;
    if (front_bank !== exp_front) begin
      n_err++;
      $display("FAIL swap_hold: got %b, want %b", front_bank, exp_front);
    end
`ifdef LIFE_SWAP_ON_SOF_EN
    repeat ($urandom_range(2, 6)) begin
      #1;
      tick();
      n_cmp++;
      if (front_bank !== exp_front || gen_count !== GW'(exp_gen)) begin
        n_err++;
        $display("FAIL swap_wait_sof: got front=%b gen=%0d, want %b %0d",
                 front_bank, gen_count, exp_front, exp_gen);
      end
    end
    disp_sof = 1;
    tick();
    disp_sof = 0;
`else
    tick();
`endif
    exp_front = !exp_front;
    exp_gen++;
    n_cmp++;
    if (front_bank !== exp_front || gen_count !== GW'(exp_gen)) begin
      n_err++;
      $display("FAIL swap_done: got front=%b gen=%0d, want %b %0d",
               front_bank, gen_count, exp_front, exp_gen);
    end
    tick();
    #1;
    n_cmp++;
    if (calc_start !== 1'b1) begin
      n_err++;
      $display("FAIL swap_restart: got %b, want 1", calc_start);
    end
    tick();
  endtask

  task automatic test_pause_swap();
    pause = 1;
    calc_gen_done = 1;
    tick();
    calc_gen_done = 0;
    disp_sof = 1;
    for (int k = 0; k < int'($urandom_range(3, 8)); k++) begin
      #1;
      n_cmp++;
      if (calc_start !== 1'b0) begin
        n_err++;
        $display("FAIL pause_start: got %b, want 0", calc_start);
      end
      tick();
      disp_sof = 0;
      n_cmp++;
      if (front_bank !== exp_front || gen_count !== GW'(exp_gen)) begin
        n_err++;
        $display("FAIL pause_hold: got front=%b gen=%0d, want %b %0d",
                 front_bank, gen_count, exp_front, exp_gen);
      end
    end
    pause = 0;
`ifdef LIFE_SWAP_ON_SOF_EN
    disp_sof = 1;
`endif
    tick();
    disp_sof = 0;
    exp_front = !exp_front;
    exp_gen++;
    n_cmp++;
    if (front_bank !== exp_front || gen_count !== GW'(exp_gen)) begin
      n_err++;
      $display("FAIL pause_swap: got front=%b gen=%0d, want %b %0d",
               front_bank, gen_count, exp_front, exp_gen);
    end
    tick();
    #1;
    n_cmp++;
    if (calc_start !== 1'b1) begin
      n_err++;
      $display("FAIL pause_restart: got %b, want 1", calc_start);
    end
    tick();
  endtask

  task automatic test_swap_drain();
    calc_gen_done = 1;
    disp_req = 1;
    disp_row = YW'($urandom_range(0, YS - 1));
    #1;
    n_cmp++;
    if (disp_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL drain_gnt: got %b, want 1", disp_gnt);
    end
    tick();
    calc_gen_done = 0;
    disp_req = 0;
`ifdef LIFE_SWAP_ON_SOF_EN
    disp_sof = 1;
`endif
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (front_bank !== exp_front || disp_rvalid !== (k == RL + 1)) begin
        n_err++;
        $display("FAIL drain_wait k=%0d: got front=%b rvalid=%b, want %b %b",
                 k, front_bank, disp_rvalid, exp_front, k == RL + 1);
      end
      tick();
      disp_sof = 0;
    end
    exp_front = !exp_front;
    exp_gen++;
    n_cmp++;
    if (front_bank !== exp_front || gen_count !== GW'(exp_gen)) begin
      n_err++;
      $display("FAIL drain_swap: got front=%b gen=%0d, want %b %0d",
               front_bank, gen_count, exp_front, exp_gen);
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    init_req = 1;
    calc_gen_done = 1;
    #1;
    n_cmp++;
    if (calc_abort !== 1'b1 || calc_start !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse: got abort=%b start=%b, want 1 0", calc_abort, calc_start);
    end
    tick();
    calc_gen_done = 0;
    n_cmp++;
    if (init_done !== 1'b0 || front_bank !== exp_front) begin
      n_err++;
      $display("FAIL abort_state: got done=%b front=%b, want 0 %b",
               init_done, front_bank, exp_front);
    end
    #1;
    n_cmp++;
    if (calc_abort !== 1'b0) begin
      n_err++;
      $display("FAIL abort_once: got %b, want 0", calc_abort);
    end
    calc_wr_valid = 1;
    calc_wr_row = 10'd7;
    tick();
    calc_wr_valid = 0;
    n_cmp++;
    if ({bram_a_we, bram_b_we} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_wr_ignored: got %b%b, want 00", bram_a_we, bram_b_we);
    end
    init_req = 0;
    init_we = 1;
    tick();
    init_we = 0;
    n_cmp++;
    if ((exp_front ? bram_b_we : bram_a_we) !== 1'b1 ||
        (exp_front ? bram_b_addr : bram_a_addr) !== '0) begin
      n_err++;
      $display("FAIL abort_reinit: got a=%b/%0d b=%b/%0d, want front we=1 addr=0",
               bram_a_we, bram_a_addr, bram_b_we, bram_b_addr);
    end
    repeat (3) tick();
    n_cmp++;
    if (gen_count !== GW'(exp_gen) || front_bank !== exp_front) begin
      n_err++;
      $display("FAIL abort_no_swap: got gen=%0d front=%b, want %0d %b",
               gen_count, front_bank, exp_gen, exp_front);
    end
  endtask

  task automatic test_reset_flush();
    rst = 1;
    tick();
    rst = 0;
    disp_req = 1;
    disp_row = 10'd9;
    #1;
    n_cmp++;
    if (disp_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_gnt: got %b, want 1", disp_gnt);
    end
    tick();
    disp_req = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({disp_rvalid, calc_rvalid} !== 2'b00) begin
        n_err++;
        $display("FAIL flush_rvalid k=%0d: got %b%b, want 00", k, disp_rvalid, calc_rvalid);
      end
      tick();
    end
    n_cmp++;
    if (front_bank !== 1'b0 || gen_count !== '0) begin
      n_err++;
      $display("FAIL flush_status: got front=%b gen=%0d, want 0 0", front_bank, gen_count);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_arbitration();
    test_calc_write();
    test_random_traffic();
    test_swap();
    test_pause_swap();
    test_swap_drain();
    test_abort();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
